// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns each rising edge of in_pulse into a level of programmable length,
// followed by a forced-low gap. Define PULSE_STRETCH_RETRIG_EN to let events during a level retrigger it.
module pulse_stretch #(
   parameter int CNT_WIDTH  = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_pulse,
   input  logic [CNT_WIDTH-1:0] stretch_len,
   output logic                 out_level,
   output logic                 toggle_out,
   output logic                 busy,
   output logic                 drop_pulse
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      STRETCH,
      GAP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len_sel;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 in_q, evt;
   logic                 out_d, toggle_d, drop_d;
   logic                 retrig_en;

`ifdef PULSE_STRETCH_RETRIG_EN
   assign retrig_en = 1'b1;
`else
   assign retrig_en = 1'b0;
`endif

   assign evt       = in_pulse & ~in_q;
   assign len_sel   = (stretch_len == '0) ? CNT_WIDTH'(1) : stretch_len;
   assign busy      = (state_q != IDLE);

   // Next-state logic; a zero-length gap skips the GAP state entirely.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      toggle_d = toggle_out;
      drop_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (evt) begin
               state_d  = STRETCH;
               cnt_d    = len_sel;
               toggle_d = ~toggle_out;
            end
         end
         STRETCH: begin
            if (evt && retrig_en) begin
               cnt_d    = len_sel;
               toggle_d = ~toggle_out;
            end else begin
               drop_d = evt;
               if (cnt_q <= CNT_WIDTH'(1)) begin
                  cnt_d = '0;
                  if (GAP_CYCLES > 0) begin
                     state_d = GAP;
                     gap_d   = GAP_W'(GAP_CYCLES);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end
            end
         end
         GAP: begin
            drop_d = evt;
            if (gap_q <= GAP_W'(1)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            gap_d   = '0;
         end
      endcase
      out_d = (state_d == STRETCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
         in_q       <= 1'b0;
         out_level  <= 1'b0;
         toggle_out <= 1'b0;
         drop_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         in_q       <= in_pulse;
         out_level  <= out_d;
         toggle_out <= toggle_d;
         drop_pulse <= drop_d;
      end
   end

endmodule
